// File: rtl/bcd_cascade_counter.sv
// Fully synchronous multi-digit modulo-N up/down counter with range-checked
// parallel load, terminal count, wrap pulse and a saturating wrap counter.
module bcd_cascade_counter #(
  parameter int DIGITS  = 4,
  parameter int MODULUS = 10,
  parameter int WRAP_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   q,
  output logic                  tc,
  output logic                  wrap,
  output logic                  load_err,
  output logic [WRAP_W-1:0]     wrap_cnt
);

  localparam logic [3:0] DIG_MAX = 4'(MODULUS - 1);
  localparam logic [4:0] DIG_MOD = 5'(MODULUS);

  logic [4*DIGITS-1:0] count_q, count_d;
  logic [4*DIGITS-1:0] step_s, loaded_s;
  logic                wrap_q, wrap_d;
  logic                load_err_q, load_err_d;
  logic [WRAP_W-1:0]   wrap_cnt_q, wrap_cnt_d;
  logic                all_max_s, all_zero_s, any_bad_s, chain_s;

  // Single-cycle carry/borrow chain plus load-value range screening.
  always_comb begin
    step_s     = count_q;
    loaded_s   = '0;
    all_max_s  = 1'b1;
    all_zero_s = 1'b1;
    any_bad_s  = 1'b0;
    chain_s    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (count_q[4*i +: 4] != DIG_MAX) all_max_s = 1'b0;
      else all_max_s = all_max_s;
      if (count_q[4*i +: 4] != 4'd0) all_zero_s = 1'b0;
      else all_zero_s = all_zero_s;

      if (!chain_s) begin
        step_s[4*i +: 4] = count_q[4*i +: 4];
      end else if (up) begin
        if (count_q[4*i +: 4] == DIG_MAX) begin
          step_s[4*i +: 4] = 4'd0;
        end else begin
          step_s[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          chain_s = 1'b0;
        end
      end else begin
        if (count_q[4*i +: 4] == 4'd0) begin
          step_s[4*i +: 4] = DIG_MAX;
        end else begin
          step_s[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          chain_s = 1'b0;
        end
      end

      if ({1'b0, load_val[4*i +: 4]} < DIG_MOD) begin
        loaded_s[4*i +: 4] = load_val[4*i +: 4];
      end else begin
        loaded_s[4*i +: 4] = 4'd0;
        any_bad_s = 1'b1;
      end
    end
    tc = en & (up ? all_max_s : all_zero_s) & ~load & ~clear & ~rst;
  end

  // Next-state selection in priority order clear > load > en > hold.
  always_comb begin
    count_d    = count_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    wrap_cnt_d = wrap_cnt_q;
    if (clear) begin
      count_d    = '0;
      wrap_cnt_d = '0;
    end else if (load) begin
      count_d    = loaded_s;
      load_err_d = any_bad_s;
    end else if (en) begin
      count_d = step_s;
      wrap_d  = tc;
      if (tc && (wrap_cnt_q != {WRAP_W{1'b1}})) wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
      else wrap_cnt_d = wrap_cnt_q;
    end else begin
      count_d = count_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
      wrap_cnt_q <= '0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  assign q        = count_q;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;
  assign wrap_cnt = wrap_cnt_q;

endmodule
